mem_access_stage: RTL and testbench

Memory-access stage of the 64-bit RV64I pipeline, between the EX/MEM register and the MEM/WB register. Takes one instruction per cycle, runs loads and stores against the data memory over a req/ready handshake, and aligns the data (byte lane steering, sign/zero extension). Outputs one registered result per instruction to MEM/WB and stalls upstream while a memory transaction is outstanding.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_align.sv | 71 +++++++
 rtl/mem_access_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the RV64I memory-access stage.
//   - funct3 encodings for loads and stores
//   - FSM state type
//   - size_mask(): byte-enable pattern for an access size, before lane shift
package mem_pkg;

  // Load encodings (stores reuse 0..3 for SB/SH/SW/SD)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // funct3[1:0] encodes log2(bytes) for every legal load and store
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data alignment for the memory-access stage.
// Ports:
//   mem_read, mem_write  access kind (both high = illegal)
//   funct3               access size / signedness
//   addr_lo              byte offset inside the doubleword
//   store_data           register value to store (LS bytes used)
//   load_word            doubleword returned by memory
//   load_data            selected field, sign/zero-extended
//   store_wdata          store data steered to its byte lanes
//   store_wstrb          byte enables for the store
//   misaligned           address not naturally aligned for the size
//   illegal              encoding not a valid load/store
module mem_align
  import mem_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [2:0]        addr_lo,
  input  logic [ADDR_W-1:0] store_data,
  input  logic [ADDR_W-1:0] load_word,
  output logic [ADDR_W-1:0] load_data,
  output logic [ADDR_W-1:0] store_wdata,
  output logic [7:0]        store_wstrb,
  output logic              misaligned,
  output logic              illegal
);

  logic [5:0]        lane_shift;
  logic [ADDR_W-1:0] lane;

  assign lane_shift = {addr_lo, 3'b000};
  assign lane       = load_word >> lane_shift;

  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path through the case leaves it unassigned (no latch).
  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{(ADDR_W-8){lane[7]}},   lane[7:0]};
      F3_H:    load_data = {{(ADDR_W-16){lane[15]}}, lane[15:0]};
      F3_W:    load_data = {{(ADDR_W-32){lane[31]}}, lane[31:0]};
      F3_D:    load_data = lane;
      F3_BU:   load_data = {{(ADDR_W-8){1'b0}},  lane[7:0]};
      F3_HU:   load_data = {{(ADDR_W-16){1'b0}}, lane[15:0]};
      F3_WU:   load_data = {{(ADDR_W-32){1'b0}}, lane[31:0]};
      default: load_data = '0;
    endcase
  end

  assign store_wdata = store_data << lane_shift;
  assign store_wstrb = size_mask(funct3[1:0]) << addr_lo;

  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'd1:    misaligned = addr_lo[0];
      2'd2:    misaligned = |addr_lo[1:0];
      2'd3:    misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  end

  // Loads have no funct3=7; stores only exist for funct3 0..3
  assign illegal = (mem_read & mem_write)
                 | (mem_read  & (funct3 == 3'd7))
                 | (mem_write & funct3[2]);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage of the RV64I pipeline (EX/MEM -> MEM/WB).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   valid_in, Mem_Read, Mem_Write,  instruction from EX/MEM
//   funct3, Mem_Address, Write_Data,
//   rd, WB
//   stall                           hold upstream this cycle
//   dmem_req/we/addr/wdata/wstrb    data-memory request (held until ready)
//   dmem_ready, dmem_rdata          data-memory response
//   valid_out, Read_Data,           registered result to MEM/WB
//   Mem_Address_out, rd_out,
//   WB_out, mem_err
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              Mem_Read,
  input  logic              Mem_Write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] Mem_Address,
  input  logic [ADDR_W-1:0] Write_Data,
  input  logic [4:0]        rd,
  input  logic [1:0]        WB,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [ADDR_W-1:0] dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic              dmem_ready,
  input  logic [ADDR_W-1:0] dmem_rdata,
  output logic              valid_out,
  output logic [ADDR_W-1:0] Read_Data,
  output logic [ADDR_W-1:0] Mem_Address_out,
  output logic [4:0]        rd_out,
  output logic [1:0]        WB_out,
  output logic              mem_err
);

  state_t state, state_nxt;

  // Instruction fields captured while a request is outstanding
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        rd_q;
  logic [1:0]        wb_q;
  logic              load_q;

  logic              in_req;
  logic              mem_op;
  logic              acc_err;
  logic              accept_alu, accept_mem, accept_err, complete;

  logic [2:0]        al_funct3;
  logic [2:0]        al_addr_lo;
  logic              al_read, al_write;
  logic [ADDR_W-1:0] al_load_data, al_wdata;
  logic [7:0]        al_wstrb;
  logic              al_misaligned, al_illegal;

  assign in_req = (state == REQ);
  assign mem_op = Mem_Read | Mem_Write;

  // One aligner serves both phases: in IDLE it checks and steers the
  // incoming store; in REQ it extracts the load using the captured fields.
  assign al_funct3  = in_req ? funct3_q    : funct3;
  assign al_addr_lo = in_req ? addr_q[2:0] : Mem_Address[2:0];
  assign al_read    = in_req ? load_q      : Mem_Read;
  assign al_write   = in_req ? ~load_q     : Mem_Write;

  mem_align #(.ADDR_W(ADDR_W)) u_align (
    .mem_read    (al_read),
    .mem_write   (al_write),
    .funct3      (al_funct3),
    .addr_lo     (al_addr_lo),
    .store_data  (Write_Data),
    .load_word   (dmem_rdata),
    .load_data   (al_load_data),
    .store_wdata (al_wdata),
    .store_wstrb (al_wstrb),
    .misaligned  (al_misaligned),
    .illegal     (al_illegal)
  );

  assign acc_err = al_misaligned | al_illegal;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_mem) state_nxt = REQ;
      REQ:     if (dmem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode. stall is gated by rst_n so it reads 0 in reset.
  always_comb begin
    accept_alu = 1'b0;
    accept_mem = 1'b0;
    accept_err = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        accept_alu = valid_in & ~mem_op;
        accept_mem = valid_in &  mem_op & ~acc_err;
        accept_err = valid_in &  mem_op &  acc_err;
      end
      REQ:     complete = dmem_ready;
      default: ;
    endcase
    stall = rst_n & (accept_mem | (in_req & ~dmem_ready));
  end

  // Datapath and MEM/WB registers
  // NOTE: the data registers are reset as well, because every output of
  // this stage must read 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q        <= '0;
      addr_q          <= '0;
      rd_q            <= '0;
      wb_q            <= '0;
      load_q          <= 1'b0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
      dmem_wstrb      <= '0;
      valid_out       <= 1'b0;
      Read_Data       <= '0;
      Mem_Address_out <= '0;
      rd_out          <= '0;
      WB_out          <= '0;
      mem_err         <= 1'b0;
    end else begin
      // Bubble unless something retires this edge
      valid_out <= 1'b0;
      WB_out    <= '0;
      mem_err   <= 1'b0;

      if (accept_alu || accept_err) begin
        valid_out       <= 1'b1;
        Read_Data       <= '0;
        Mem_Address_out <= Mem_Address;
        rd_out          <= rd;
        WB_out          <= accept_err ? {1'b0, WB[0]} : WB;
        mem_err         <= accept_err;
      end

      if (accept_mem) begin
        funct3_q   <= funct3;
        addr_q     <= Mem_Address;
        rd_q       <= rd;
        wb_q       <= WB;
        load_q     <= Mem_Read;
        dmem_req   <= 1'b1;
        dmem_we    <= Mem_Write;
        dmem_addr  <= {Mem_Address[ADDR_W-1:3], 3'b000};
        dmem_wdata <= Mem_Write ? al_wdata : '0;
        dmem_wstrb <= Mem_Write ? al_wstrb : 8'h00;
      end

      if (complete) begin
        valid_out       <= 1'b1;
        Read_Data       <= load_q ? al_load_data : '0;
        Mem_Address_out <= addr_q;
        rd_out          <= rd_q;
        WB_out          <= wb_q;
        dmem_req        <= 1'b0;
        dmem_we         <= 1'b0;
        dmem_wstrb      <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage. Expected retirements are pushed
// to a scoreboard when an instruction is driven; a negedge monitor pops and
// compares them whenever valid_out pulses.
module tb_mem_access_stage;

  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              valid_in = 1'b0;
  logic              Mem_Read = 1'b0;
  logic              Mem_Write = 1'b0;
  logic [2:0]        funct3 = '0;
  logic [ADDR_W-1:0] Mem_Address = '0;
  logic [ADDR_W-1:0] Write_Data = '0;
  logic [4:0]        rd = '0;
  logic [1:0]        WB = '0;
  logic              stall;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [ADDR_W-1:0] dmem_wdata;
  logic [7:0]        dmem_wstrb;
  logic              dmem_ready = 1'b0;
  logic [ADDR_W-1:0] dmem_rdata = '0;
  logic              valid_out;
  logic [ADDR_W-1:0] Read_Data;
  logic [ADDR_W-1:0] Mem_Address_out;
  logic [4:0]        rd_out;
  logic [1:0]        WB_out;
  logic              mem_err;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_in        (valid_in),
    .Mem_Read        (Mem_Read),
    .Mem_Write       (Mem_Write),
    .funct3          (funct3),
    .Mem_Address     (Mem_Address),
    .Write_Data      (Write_Data),
    .rd              (rd),
    .WB              (WB),
    .stall           (stall),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_wstrb      (dmem_wstrb),
    .dmem_ready      (dmem_ready),
    .dmem_rdata      (dmem_rdata),
    .valid_out       (valid_out),
    .Read_Data       (Read_Data),
    .Mem_Address_out (Mem_Address_out),
    .rd_out          (rd_out),
    .WB_out          (WB_out),
    .mem_err         (mem_err)
  );

  typedef struct {
    logic [63:0] read_data;
    logic [63:0] addr;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   ret_cyc[32];

  // Retirement monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (rst_n && valid_out) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_valid_out: rd_out=%0d with nothing expected", rd_out);
      end else begin
        e = sb_q.pop_front();
        if (Read_Data !== e.read_data || Mem_Address_out !== e.addr ||
            rd_out !== e.rd || WB_out !== e.wb || mem_err !== e.err) begin
          miscompares++;
          $display("FAIL retire_rd%0d: got data=%h addr=%h rd=%0d wb=%b err=%b, want data=%h addr=%h rd=%0d wb=%b err=%b",
                   e.rd, Read_Data, Mem_Address_out, rd_out, WB_out, mem_err,
                   e.read_data, e.addr, e.rd, e.wb, e.err);
        end
      end
      ret_cyc[rd_out] = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [63:0] data, input logic [63:0] addr,
                          input logic [4:0] rd_v, input logic [1:0] wb_v,
                          input logic err);
    exp_t e;
    e.read_data = data;
    e.addr      = addr;
    e.rd        = rd_v;
    e.wb        = wb_v;
    e.err       = err;
    sb_q.push_back(e);
  endtask

  // Present one instruction and serve its memory request (if any) with
  // 'waits' wait cycles. Checks the request fields every outstanding cycle.
  // Returns with the instruction being accepted on the next rising edge.
  task automatic send(input logic rd_i, input logic wr_i, input logic [2:0] f3,
                      input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [4:0] rd_v, input logic [1:0] wb_v,
                      input int waits, input logic [63:0] rdata,
                      input logic [63:0] exp_daddr, input logic [7:0] exp_strb,
                      input logic [63:0] exp_wdata, output int stall_cycles);
    int n;
    int waited;
    @(negedge clk);
    valid_in    = 1'b1;
    Mem_Read    = rd_i;
    Mem_Write   = wr_i;
    funct3      = f3;
    Mem_Address = addr;
    Write_Data  = wdata;
    rd          = rd_v;
    WB          = wb_v;
    dmem_ready  = 1'b0;
    dmem_rdata  = 64'h5A5A_5A5A_5A5A_5A5A;
    stall_cycles = 0;
    waited = 0;
    n = 0;
    #1;
    while (stall && n < 64) begin
      stall_cycles++;
      @(negedge clk);
      vectors++;
      if (dmem_req !== 1'b1 || dmem_addr !== exp_daddr || dmem_we !== wr_i ||
          valid_out !== 1'b0 ||
          (wr_i && (dmem_wstrb !== exp_strb || dmem_wdata !== exp_wdata))) begin
        miscompares++;
        $display("FAIL request_rd%0d: req=%b we=%b addr=%h strb=%h wdata=%h vo=%b, want req=1 we=%b addr=%h strb=%h wdata=%h vo=0",
                 rd_v, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, valid_out,
                 wr_i, exp_daddr, exp_strb, exp_wdata);
      end
      if (waited == waits) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
      end else begin
        dmem_ready = 1'b0;
        dmem_rdata = ~rdata;
        waited++;
      end
      #1;
      n++;
    end
    if (n >= 64) begin
      vectors++;
      miscompares++;
      $display("FAIL stall_timeout_rd%0d: stall still high after %0d cycles", rd_v, n);
    end
  endtask

  task automatic bubble();
    @(negedge clk);
    valid_in   = 1'b0;
    Mem_Read   = 1'b0;
    Mem_Write  = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    // Reset asserted with a legal load presented: stall must still read 0
    valid_in  = 1'b1;
    Mem_Read  = 1'b1;
    funct3    = 3'd3;
    #1 rst_n = 1'b0;
    #2;
    vectors++;
    if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, valid_out,
         Read_Data, Mem_Address_out, rd_out, WB_out, mem_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: stall=%b req=%b vo=%b rd=%0d wb=%b err=%b data=%h, want all 0",
               stall, dmem_req, valid_out, rd_out, WB_out, mem_err, Read_Data);
    end
    valid_in = 1'b0;
    Mem_Read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    int sc;
    push_exp(64'h0, 64'h1234, 5'd7, 2'b10, 1'b0);
    send(1'b0, 1'b0, 3'd0, 64'h1234, 64'h0, 5'd7, 2'b10, 0, 64'h0, 64'h0, 8'h0, 64'h0, sc);
    vectors++;
    if (sc !== 0) begin
      miscompares++;
      $display("FAIL alu_stall: %0d stall cycles, want 0", sc);
    end
    bubble();
    bubble();
    vectors++;
    if (valid_out !== 1'b0 || WB_out !== 2'b00) begin
      miscompares++;
      $display("FAIL bubble: valid_out=%b WB_out=%b, want 0 and 00", valid_out, WB_out);
    end
  endtask

  task automatic test_lb();
    int sc;
    push_exp(64'hFFFF_FFFF_FFFF_FF80, 64'h1007, 5'd5, 2'b11, 1'b0);
    send(1'b1, 1'b0, 3'd0, 64'h1007, 64'h0, 5'd5, 2'b11, 0,
         64'h80AA_BBCC_DDEE_FF11, 64'h1000, 8'h0, 64'h0, sc);
    vectors++;
    if (sc !== 1) begin
      miscompares++;
      $display("FAIL lb_stall: %0d stall cycles, want 1", sc);
    end
    bubble();
    vectors++;
    if (valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL lb_latency: valid_out=%b after 2nd edge, want 1", valid_out);
    end
  endtask

  task automatic test_lhu_wait();
    int sc;
    push_exp(64'h0000_0000_0000_BEEF, 64'h2002, 5'd6, 2'b11, 1'b0);
    send(1'b1, 1'b0, 3'd5, 64'h2002, 64'h0, 5'd6, 2'b11, 3,
         64'h1111_2222_BEEF_3333, 64'h2000, 8'h0, 64'h0, sc);
    vectors++;
    if (sc !== 4) begin
      miscompares++;
      $display("FAIL lhu_stall: %0d stall cycles, want 4", sc);
    end
    bubble();
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [63:0] want;
  } ld_vec_t;

  task automatic test_loads();
    ld_vec_t lv[5];
    int sc;
    lv[0] = '{3'd2, 64'h4004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321};
    lv[1] = '{3'd6, 64'h4004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321};
    lv[2] = '{3'd1, 64'h4006, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_FFFF_8765};
    lv[3] = '{3'd4, 64'h4001, 64'h0000_0000_0000_F000, 64'h0000_0000_0000_00F0};
    lv[4] = '{3'd3, 64'h4008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 5; i++) begin
      push_exp(lv[i].want, lv[i].addr, 5'(12 + i), 2'b11, 1'b0);
      send(1'b1, 1'b0, lv[i].f3, lv[i].addr, 64'h0, 5'(12 + i), 2'b11, i % 2,
           lv[i].rdata, {lv[i].addr[63:3], 3'b000}, 8'h0, 64'h0, sc);
    end
    bubble();
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } st_vec_t;

  task automatic test_stores();
    st_vec_t sv[4];
    int sc;
    sv[0] = '{3'd0, 64'h3005, 64'h0000_0000_0000_00AB, 8'b0010_0000, 64'h0000_AB00_0000_0000};
    sv[1] = '{3'd1, 64'h300A, 64'h0000_0000_0000_CAFE, 8'b0000_1100, 64'h0000_0000_CAFE_0000};
    sv[2] = '{3'd2, 64'h3004, 64'hFFFF_FFFF_1234_5678, 8'b1111_0000, 64'h1234_5678_0000_0000};
    sv[3] = '{3'd3, 64'h3008, 64'h0123_4567_89AB_CDEF, 8'b1111_1111, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 4; i++) begin
      push_exp(64'h0, sv[i].addr, 5'(20 + i), 2'b00, 1'b0);
      send(1'b0, 1'b1, sv[i].f3, sv[i].addr, sv[i].data, 5'(20 + i), 2'b00, i,
           64'hFFFF_0000_FFFF_0000, {sv[i].addr[63:3], 3'b000}, sv[i].strb, sv[i].wdata, sc);
    end
    bubble();
  endtask

  typedef struct {
    logic        rd_i;
    logic        wr_i;
    logic [2:0]  f3;
    logic [63:0] addr;
  } err_vec_t;

  task automatic test_errors();
    err_vec_t ev[6];
    int sc;
    ev[0] = '{1'b1, 1'b0, 3'd2, 64'h4002};  // misaligned LW
    ev[1] = '{1'b1, 1'b0, 3'd7, 64'h4000};  // load funct3=7
    ev[2] = '{1'b0, 1'b1, 3'd4, 64'h4000};  // store funct3=4
    ev[3] = '{1'b1, 1'b1, 3'd3, 64'h4000};  // read and write
    ev[4] = '{1'b1, 1'b0, 3'd1, 64'h4001};  // misaligned LH
    ev[5] = '{1'b0, 1'b1, 3'd3, 64'h4004};  // misaligned SD
    for (int i = 0; i < 6; i++) begin
      push_exp(64'h0, ev[i].addr, 5'(24 + i), 2'b01, 1'b1);
      send(ev[i].rd_i, ev[i].wr_i, ev[i].f3, ev[i].addr, 64'hFFFF_FFFF_FFFF_FFFF,
           5'(24 + i), 2'b11, 0, 64'h0, 64'h0, 8'h0, 64'h0, sc);
      bubble();
      vectors++;
      if (sc !== 0 || dmem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL error_case%0d: stall_cycles=%0d dmem_req=%b, want 0 and 0", i, sc, dmem_req);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sc;
    ret_cyc[8] = -100;
    ret_cyc[9] = -100;
    ret_cyc[10] = -100;
    push_exp(64'h0, 64'hAAAA, 5'd8, 2'b10, 1'b0);
    push_exp(64'h0123_4567_89AB_CDEF, 64'h5008, 5'd9, 2'b11, 1'b0);
    push_exp(64'h0, 64'hBBBB, 5'd10, 2'b10, 1'b0);
    send(1'b0, 1'b0, 3'd0, 64'hAAAA, 64'h0, 5'd8, 2'b10, 0, 64'h0, 64'h0, 8'h0, 64'h0, sc);
    send(1'b1, 1'b0, 3'd3, 64'h5008, 64'h0, 5'd9, 2'b11, 0,
         64'h0123_4567_89AB_CDEF, 64'h5008, 8'h0, 64'h0, sc);
    send(1'b0, 1'b0, 3'd0, 64'hBBBB, 64'h0, 5'd10, 2'b10, 0, 64'h0, 64'h0, 8'h0, 64'h0, sc);
    bubble();
    bubble();
    vectors++;
    if (ret_cyc[9] - ret_cyc[8] != 2 || ret_cyc[10] - ret_cyc[9] != 1) begin
      miscompares++;
      $display("FAIL b2b_pattern: retire gaps %0d,%0d, want 2,1",
               ret_cyc[9] - ret_cyc[8], ret_cyc[10] - ret_cyc[9]);
    end
  endtask

  task automatic test_reset_mid_req();
    int sc;
    @(negedge clk);
    valid_in    = 1'b1;
    Mem_Read    = 1'b1;
    Mem_Write   = 1'b0;
    funct3      = 3'd3;
    Mem_Address = 64'h6000;
    rd          = 5'd11;
    WB          = 2'b11;
    dmem_ready  = 1'b0;
    @(negedge clk);
    vectors++;
    if (dmem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL midreq_setup: dmem_req=%b, want 1", dmem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, valid_out,
         Read_Data, Mem_Address_out, rd_out, WB_out, mem_err} !== '0) begin
      miscompares++;
      $display("FAIL midreq_reset: stall=%b req=%b addr=%h vo=%b rd=%0d, want all 0",
               stall, dmem_req, dmem_addr, valid_out, rd_out);
    end
    valid_in = 1'b0;
    Mem_Read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bubble();
      vectors++;
      if (valid_out !== 1'b0 || dmem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL midreq_after%0d: valid_out=%b dmem_req=%b, want 0 and 0", i, valid_out, dmem_req);
      end
    end
    // Stage must be back in IDLE: an ALU op retires with latency 1
    push_exp(64'h0, 64'h7777, 5'd31, 2'b10, 1'b0);
    send(1'b0, 1'b0, 3'd0, 64'h7777, 64'h0, 5'd31, 2'b10, 0, 64'h0, 64'h0, 8'h0, 64'h0, sc);
    bubble();
    vectors++;
    if (valid_out !== 1'b1 || rd_out !== 5'd31) begin
      miscompares++;
      $display("FAIL midreq_idle: valid_out=%b rd_out=%0d, want 1 and 31", valid_out, rd_out);
    end
  endtask

  initial begin
    int n;
    test_reset();
    test_alu();
    test_lb();
    test_lhu_wait();
    test_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid_req();
    bubble();
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected results never retired, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
